// File: rtl/rr_arb_mux_4_1.sv
// Four-requester round-robin arbiter feeding one 4:1 data mux into a registered one-entry output stage.
// Optional macro RR_ARB_LOCK_EN adds req_last and holds the grant on one requester until its last beat.
module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_vld,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
`ifdef RR_ARB_LOCK_EN
  input  logic [3:0]       req_last,
`endif
  output logic [3:0]       req_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_rdy
);

  logic [1:0]       ptr_q, ptr_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             can_load_s;
  logic             win_found_s;
  logic [1:0]       win_idx_s;
  logic             xfer_s;
  logic [WIDTH-1:0] mux_data_s;
`ifdef RR_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [1:0]       lock_idx_q, lock_idx_d;
`endif

  // Returns {found, index} of the first valid requester scanning from ptr upward, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] vld, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && vld[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Arbitration, ready generation and 4:1 data mux.
  always_comb begin
    can_load_s = !out_vld_q || out_rdy;
    {win_found_s, win_idx_s} = rr_pick(req_vld, ptr_q);
`ifdef RR_ARB_LOCK_EN
    // A locked burst owns the mux; nobody else may win even if the owner idles.
    if (lock_q) begin
      win_found_s = req_vld[lock_idx_q];
      win_idx_s   = lock_idx_q;
    end else begin
      win_found_s = win_found_s;
    end
`endif
    xfer_s  = !rst && can_load_s && win_found_s;
    req_rdy = 4'b0000;
    if (xfer_s) begin
      req_rdy[win_idx_s] = 1'b1;
    end else begin
      req_rdy = 4'b0000;
    end
    case (win_idx_s)
      2'd0:    mux_data_s = req_data0;
      2'd1:    mux_data_s = req_data1;
      2'd2:    mux_data_s = req_data2;
      2'd3:    mux_data_s = req_data3;
      default: mux_data_s = req_data0;
    endcase
  end

  // Next-state for the pointer, the output stage and the optional burst lock.
  always_comb begin
    ptr_d      = ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
`ifdef RR_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    if (xfer_s) begin
      out_vld_d  = 1'b1;
      out_data_d = mux_data_s;
      out_sel_d  = win_idx_s;
`ifdef RR_ARB_LOCK_EN
      if (req_last[win_idx_s]) begin
        lock_d = 1'b0;
        ptr_d  = win_idx_s + 2'd1;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = win_idx_s;
      end
`else
      ptr_d = win_idx_s + 2'd1;
`endif
    end else if (can_load_s) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 2'd0;
      out_vld_q  <= 1'b0;
      out_data_q <= {WIDTH{1'b0}};
      out_sel_q  <= 2'd0;
`ifdef RR_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= 2'd0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
`ifdef RR_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed table-driven bench for rr_arb_mux_4_1 plus hand-written reset-mid-hold and burst-lock sequences.
module tb_rr_arb_mux_4_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vld;
  logic [3:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0] req_last;
  logic [3:0] req_rdy;
  logic       out_vld;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_rdy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rr_arb_mux_4_1 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
`ifdef RR_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .req_rdy   (req_rdy),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_rdy   (out_rdy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] d0, d1, d2, d3;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [3:0] e_od;
    logic [1:0] e_os;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
  endtask

  // Drive one cycle's inputs at the falling edge, check ready before the rising edge and outputs after it.
  task automatic step(input int idx, input vec_t v);
    @(negedge clk);
    rst = v.rst; req_vld = v.vld; out_rdy = v.ordy;
    req_data0 = v.d0; req_data1 = v.d1; req_data2 = v.d2; req_data3 = v.d3;
    #1;
    chk("req_rdy", idx, {4'h0, req_rdy}, {4'h0, v.e_rdy});
    @(posedge clk);
    #1;
    chk("out_vld", idx, {7'h0, out_vld}, {7'h0, v.e_ov});
    if (v.e_ov || v.rst) begin
      chk("out_data", idx, {4'h0, out_data}, {4'h0, v.e_od});
      chk("out_sel", idx, {6'h0, out_sel}, {6'h0, v.e_os});
    end else begin
      chk("out_data_hold", idx, {4'h0, out_data}, {4'h0, v.e_od});
    end
  endtask

  initial begin
    rst = 1'b1; req_vld = 4'h0; out_rdy = 1'b0; req_last = 4'hF;
    req_data0 = 4'h0; req_data1 = 4'h0; req_data2 = 4'h0; req_data3 = 4'h0;

    //         rst   vld    d0     d1     d2     d3    ordy  e_rdy   e_ov  e_od   e_os
    tbl[0]  = '{1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};
    tbl[2]  = '{1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    tbl[3]  = '{1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    tbl[4]  = '{1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    tbl[5]  = '{1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3};
    tbl[6]  = '{1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    tbl[7]  = '{1'b0, 4'h4, 4'hA, 4'hB, 4'h5, 4'hD, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2};
    tbl[8]  = '{1'b0, 4'h4, 4'hA, 4'hB, 4'h5, 4'hD, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2};
    tbl[9]  = '{1'b0, 4'h4, 4'hA, 4'hB, 4'h5, 4'hD, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2};
    tbl[10] = '{1'b0, 4'h4, 4'hA, 4'hB, 4'h5, 4'hD, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2};
    tbl[11] = '{1'b0, 4'h1, 4'h7, 4'hB, 4'h5, 4'hD, 1'b1, 4'b0001, 1'b1, 4'h7, 2'd0};
    tbl[12] = '{1'b0, 4'h4, 4'h7, 4'hB, 4'h9, 4'hD, 1'b1, 4'b0100, 1'b1, 4'h9, 2'd2};
    tbl[13] = '{1'b0, 4'h3, 4'h1, 4'h2, 4'h9, 4'hD, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    tbl[14] = '{1'b0, 4'h3, 4'h1, 4'h2, 4'h9, 4'hD, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    tbl[15] = '{1'b0, 4'h0, 4'h1, 4'h2, 4'h9, 4'hD, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd1};
    tbl[16] = '{1'b0, 4'h0, 4'h1, 4'h2, 4'h9, 4'hD, 1'b0, 4'b0000, 1'b0, 4'h2, 2'd1};
    tbl[17] = '{1'b0, 4'hA, 4'h1, 4'h6, 4'h9, 4'h8, 1'b0, 4'b1000, 1'b1, 4'h8, 2'd3};
    tbl[18] = '{1'b0, 4'hA, 4'h1, 4'h6, 4'h9, 4'h8, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd3};
    tbl[19] = '{1'b0, 4'hA, 4'h1, 4'h6, 4'h9, 4'h8, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1};

    for (int i = 0; i < 20; i++) step(i, tbl[i]);

    // Reset while a beat (6 from requester 1) is held under backpressure: it must vanish.
    step(100, '{1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h6, 2'd1});
    step(101, '{1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0});
    step(102, '{1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0});
    step(103, '{1'b0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0});

`ifdef RR_ARB_LOCK_EN
    // Requester 1 holds the mux for a three-beat burst; requester 0 waits until the last beat.
    req_last = 4'b0000;
    step(200, '{1'b0, 4'h3, 4'h5, 4'h6, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1});
    step(201, '{1'b0, 4'h3, 4'h5, 4'h7, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h7, 2'd1});
    req_last = 4'b0010;
    step(202, '{1'b0, 4'h3, 4'h5, 4'h8, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h8, 2'd1});
    req_last = 4'hF;
    step(203, '{1'b0, 4'h3, 4'h5, 4'h9, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
